pipe_ctrl: RTL and testbench

Central pipeline sequencer for the 5-stage RISC-V core. Combines load-use hazard detection, ID-stage branch flush and a multi-cycle data-memory wait handshake into one prioritised set of register enables, flushes and bubbles. A start/run/halt state machine wraps these controls, with a memory-wait watchdog. Sits beside the pipeline registers in the CPU top and drives their write-enable and flush inputs.

---
 rtl/pipe_ctrl_pkg.sv | 6 +
 rtl/pipe_ctrl_mem_wait_timer.sv | 21 ++
 rtl/pipe_ctrl.sv | 80 ++++++++
 tb/tb_pipe_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state type and constants for the pipeline sequencer
package pipe_ctrl_pkg;
   typedef enum logic [1:0] {IDLE, RUN, MEM_WAIT, HALT} state_e;
   localparam int REG_W = 5;
   localparam int TIMEOUT_DEFAULT = 64;
endpackage

// File: rtl/pipe_ctrl_mem_wait_timer.sv
// mem_wait_timer: counts consecutive frozen cycles of one memory access and flags the timeout cycle
module mem_wait_timer
   import pipe_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic count,
   input  logic clear,
   output logic expired
);
   localparam int W = $clog2(TIMEOUT_CYCLES + 1);
   logic [W-1:0] cnt_q;
   // clear wins so every new access starts counting from zero
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) cnt_q <= '0;
      else if (clear) cnt_q <= '0;
      else if (count) cnt_q <= cnt_q + 1'b1;
   assign expired = count && cnt_q == W'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline sequencer (load-use stall, branch flush, memory wait, watchdog halt); PIPE_CTRL_PERF_EN builds the perf counters
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
   parameter int CNT_W = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [REG_W-1:0] ex_rd_i,
   input  logic             ex_mem_read_i,
   input  logic             ex_reg_write_i,
   input  logic [REG_W-1:0] id_rs1_i,
   input  logic [REG_W-1:0] id_rs2_i,
   input  logic             branch_taken_i,
   input  logic             mem_req_i,
   input  logic             mem_ack_i,
   output logic             pc_we_o,
   output logic             ifid_we_o,
   output logic             ifid_flush_o,
   output logic             idex_bubble_o,
   output logic             pipe_we_o,
   output logic             running_o,
   output logic             err_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] wait_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o
);
   state_e state_q, state_d;
   logic load_use, freeze, expired;
   assign running_o = state_q == RUN || state_q == MEM_WAIT;
   assign load_use = ex_mem_read_i && ex_reg_write_i && ex_rd_i != '0 &&
                     (ex_rd_i == id_rs1_i || ex_rd_i == id_rs2_i);
   assign freeze = !mem_ack_i && (state_q == MEM_WAIT || (state_q == RUN && mem_req_i));
   assign pipe_we_o = running_o && !freeze;
   assign pc_we_o = pipe_we_o && !load_use;
   assign ifid_we_o = pc_we_o;
   assign idex_bubble_o = pipe_we_o && load_use;
   assign ifid_flush_o = pc_we_o && branch_taken_i;
   assign err_o = state_q == HALT;
   mem_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .count   (freeze),
      .clear   (!freeze),
      .expired (expired)
   );
   // state register; HALT is left only through reset
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) state_q <= IDLE;
      else state_q <= state_d;
   // next state: an ack in the timeout cycle still returns to RUN
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     state_d = start_i ? RUN : IDLE;
         RUN:      state_d = mem_req_i && !mem_ack_i ? MEM_WAIT : RUN;
         MEM_WAIT: state_d = mem_ack_i ? RUN : expired ? HALT : MEM_WAIT;
         default:  state_d = HALT;
      endcase
   end
`ifdef PIPE_CTRL_PERF_EN
   // event counters advance only while the pipeline is live and wrap naturally
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         stall_cnt_o <= '0;
         wait_cnt_o  <= '0;
         flush_cnt_o <= '0;
      end else if (running_o) begin
         stall_cnt_o <= stall_cnt_o + CNT_W'(idex_bubble_o);
         wait_cnt_o  <= wait_cnt_o + CNT_W'(freeze);
         flush_cnt_o <= flush_cnt_o + CNT_W'(ifid_flush_o);
      end
`else
   assign stall_cnt_o = '0;
   assign wait_cnt_o  = '0;
   assign flush_cnt_o = '0;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed tables, corner sequences and a randomized run against a behavioural model
module tb_pipe_ctrl;
   localparam int TO = 4;
   localparam int CW = 32;
   logic clk = 0, rst = 1, start = 0;
   logic [4:0] ex_rd = 0, rs1 = 0, rs2 = 0;
   logic ex_mr = 0, ex_rw = 0, br = 0, req = 0, ack = 0;
   logic pc_we, ifid_we, ifid_flush, idex_bubble, pipe_we, running, err;
   logic [CW-1:0] stall_cnt, wait_cnt, flush_cnt;
   int total = 0, bad = 0;
   bit m_on, m_halt;
   int m_wait, ms, mw, mf;

   typedef struct {
      string name;
      logic [4:0] rd;
      logic mr, rw;
      logic [4:0] r1, r2;
      logic b;
      logic [6:0] exp;
   } vec_t;
   vec_t tv[9];

   pipe_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start),
      .ex_rd_i(ex_rd), .ex_mem_read_i(ex_mr), .ex_reg_write_i(ex_rw),
      .id_rs1_i(rs1), .id_rs2_i(rs2), .branch_taken_i(br),
      .mem_req_i(req), .mem_ack_i(ack),
      .pc_we_o(pc_we), .ifid_we_o(ifid_we), .ifid_flush_o(ifid_flush),
      .idex_bubble_o(idex_bubble), .pipe_we_o(pipe_we), .running_o(running), .err_o(err),
      .stall_cnt_o(stall_cnt), .wait_cnt_o(wait_cnt), .flush_cnt_o(flush_cnt)
   );

   always #5 clk = ~clk;

   // control word order: pc_we, ifid_we, ifid_flush, idex_bubble, pipe_we, running, err
   function automatic logic [6:0] dut_ctl();
      return {pc_we, ifid_we, ifid_flush, idex_bubble, pipe_we, running, err};
   endfunction

   function automatic logic lu();
      return ex_mr && ex_rw && ex_rd != 0 && (ex_rd == rs1 || ex_rd == rs2);
   endfunction

   function automatic logic frz();
      return m_on && !m_halt && !ack && (m_wait > 0 || req);
   endfunction

   function automatic logic [6:0] model_ctl();
      if (!m_on || m_halt) return {6'b0, m_halt};
      if (frz()) return 7'b0000010;
      if (lu()) return 7'b0001110;
      return br ? 7'b1110110 : 7'b1100110;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_ctl(input string name, input logic [6:0] exp);
      chk(name, 32'(dut_ctl()), 32'(exp));
   endtask

   task automatic check_all(input string name);
      chk_ctl({name, "/ctl"}, model_ctl());
`ifdef PIPE_CTRL_PERF_EN
      chk({name, "/stall_cnt"}, stall_cnt, 32'(ms));
      chk({name, "/wait_cnt"}, wait_cnt, 32'(mw));
      chk({name, "/flush_cnt"}, flush_cnt, 32'(mf));
`else
      chk({name, "/stall_cnt"}, stall_cnt, 0);
      chk({name, "/wait_cnt"}, wait_cnt, 0);
      chk({name, "/flush_cnt"}, flush_cnt, 0);
`endif
   endtask

   // advance the model by one clock using the inputs currently applied, then step the DUT
   task automatic tick();
      if (m_on && !m_halt) begin
         if (frz()) begin
            mw++;
            m_wait++;
            if (m_wait == TO) m_halt = 1;
         end else begin
            m_wait = 0;
            if (lu()) ms++;
            else if (br) mf++;
         end
      end else if (!m_on && start) m_on = 1;
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_on = 0; m_halt = 0; m_wait = 0; ms = 0; mw = 0; mf = 0;
   endtask

   task automatic clear_in();
      start = 0; req = 0; ack = 0; br = 0; ex_mr = 0; ex_rw = 0; ex_rd = 0; rs1 = 0; rs2 = 0;
   endtask

   task automatic do_reset();
      rst = 1;
      #1;
      model_reset();
      check_all("reset");
      @(posedge clk);
      #1;
      rst = 0;
   endtask

   initial begin
      tv[0] = '{"lu_rs2",      5'd5, 1, 1, 5'd0, 5'd5, 0, 7'b0001110};
      tv[1] = '{"lu_rd0",      5'd0, 1, 1, 5'd0, 5'd0, 0, 7'b1100110};
      tv[2] = '{"lu_rs1",      5'd5, 1, 1, 5'd5, 5'd9, 0, 7'b0001110};
      tv[3] = '{"no_load",     5'd5, 0, 1, 5'd5, 5'd5, 0, 7'b1100110};
      tv[4] = '{"no_regwrite", 5'd5, 1, 0, 5'd5, 5'd5, 0, 7'b1100110};
      tv[5] = '{"no_match",    5'd7, 1, 1, 5'd5, 5'd6, 0, 7'b1100110};
      tv[6] = '{"branch",      5'd0, 0, 0, 5'd0, 5'd0, 1, 7'b1110110};
      tv[7] = '{"branch_lu",   5'd5, 1, 1, 5'd0, 5'd5, 1, 7'b0001110};
      tv[8] = '{"branch_rd0",  5'd0, 1, 1, 5'd0, 5'd0, 1, 7'b1110110};

      do_reset();
      for (int c = 0; c < 3; c++) begin
         start = c == 2;
         #1;
         chk_ctl($sformatf("idle_c%0d", c), 7'b0);
         tick();
      end
      start = 0;
      #1;
      chk_ctl("run_c3", 7'b1100110);

      for (int i = 0; i < 9; i++) begin
         ex_rd = tv[i].rd; ex_mr = tv[i].mr; ex_rw = tv[i].rw;
         rs1 = tv[i].r1; rs2 = tv[i].r2; br = tv[i].b;
         #1;
         chk_ctl(tv[i].name, tv[i].exp);
      end
      clear_in();

      req = 1;
      for (int c = 0; c < 4; c++) begin
         ack = c == 3;
         #1;
         chk_ctl($sformatf("memwait_c%0d", c), c == 3 ? 7'b1100110 : 7'b0000010);
         tick();
      end
      clear_in();
      #1;
      chk_ctl("memwait_after", 7'b1100110);
`ifdef PIPE_CTRL_PERF_EN
      chk("memwait_cnt", wait_cnt, 3);
`endif
      check_all("memwait_model");

      req = 1;
      for (int c = 0; c < 4; c++) begin
         #1;
         chk_ctl($sformatf("timeout_c%0d", c), 7'b0000010);
         tick();
      end
      #1;
      chk_ctl("halt", 7'b0000001);
      for (int c = 0; c < 5; c++) begin
         start = 1'($urandom); req = 1'($urandom); ack = 1'($urandom); br = 1'($urandom);
         ex_mr = 1; ex_rw = 1; ex_rd = 5'd3; rs1 = 5'd3;
         #1;
         chk_ctl($sformatf("halt_hold%0d", c), 7'b0000001);
         tick();
      end
      clear_in();
      do_reset();
      chk_ctl("halt_cleared", 7'b0);

      start = 1;
      tick();
      start = 0;
      req = 1;
      for (int c = 0; c < 4; c++) begin
         ack = c == 3;
         #1;
         chk_ctl($sformatf("ack4_c%0d", c), c == 3 ? 7'b1100110 : 7'b0000010);
         tick();
      end
      clear_in();
      #1;
      chk_ctl("ack4_run", 7'b1100110);

      req = 1;
      tick();
      #2;
      rst = 1;
      #1;
      chk_ctl("async_rst_ctl", 7'b0);
      chk("async_rst_stall", stall_cnt, 0);
      chk("async_rst_wait", wait_cnt, 0);
      chk("async_rst_flush", flush_cnt, 0);
      model_reset();
      @(posedge clk);
      #1;
      rst = 0;
      clear_in();
      #1;
      chk_ctl("async_rst_idle", 7'b0);

      for (int n = 0; n < 400; n++) begin
         if (m_halt && $urandom_range(3) == 0) begin
            clear_in();
            do_reset();
         end
         start = $urandom_range(3) != 0;
         req = $urandom_range(2) == 0;
         ack = $urandom_range(3) == 0;
         br = $urandom_range(3) == 0;
         ex_mr = 1'($urandom); ex_rw = 1'($urandom);
         ex_rd = 5'($urandom_range(3)); rs1 = 5'($urandom_range(3)); rs2 = 5'($urandom_range(3));
         #1;
         check_all($sformatf("rnd%0d", n));
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
